// File: rtl/sandpiper_pkg.sv
// Shared definitions for the Sandpiper hex character writer: segment layout,
// glyph constants, FSM state encoding and the hex glyph lookup.
package sandpiper_pkg;

  localparam int SEG_BIT_A  = 0;
  localparam int SEG_BIT_B  = 1;
  localparam int SEG_BIT_C  = 2;
  localparam int SEG_BIT_D  = 3;
  localparam int SEG_BIT_E  = 4;
  localparam int SEG_BIT_F  = 5;
  localparam int SEG_BIT_G  = 6;
  localparam int SEG_BIT_DP = 7;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DP    = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  // Pattern bits are {DP,G,F,E,D,C,B,A}; DP is never set by the glyph itself.
  function automatic logic [7:0] hex_glyph(input logic [3:0] nibble);
    logic [7:0] g;
    case (nibble)
      4'h0: g = 8'h3F;
      4'h1: g = 8'h06;
      4'h2: g = 8'h5B;
      4'h3: g = 8'h4F;
      4'h4: g = 8'h66;
      4'h5: g = 8'h6D;
      4'h6: g = 8'h7D;
      4'h7: g = 8'h07;
      4'h8: g = 8'h7F;
      4'h9: g = 8'h6F;
      4'hA: g = 8'h77;
      4'hB: g = 8'h7C;
      4'hC: g = 8'h39;
      4'hD: g = 8'h5E;
      4'hE: g = 8'h79;
      default: g = 8'h71;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sandpiper_hex_to_seg.sv
// Combinational nibble-to-segment decode with blanking and decimal point.
module sandpiper_hex_to_seg
  import sandpiper_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  // DP is ORed in after blanking so a blanked character can still show its dot.
  always_comb begin
    seg = blank ? SEG_BLANK : hex_glyph(nibble);
    if (dp) begin
      seg = seg | SEG_DP;
    end
  end

endmodule

// File: rtl/sandpiper_hex_char_writer.sv
// Accepts a 32-bit word and writes its eight hex glyphs into the 7-segment
// driver, one character per commit_char high/low pulse.
module sandpiper_hex_char_writer
  import sandpiper_pkg::*;
#(
  parameter int CHAR_CT   = 8,
  parameter int DIMMING_W = 8,
  parameter int COMMIT_HI = 2,
  parameter int COMMIT_LO = 2
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_value,
  input  logic [CHAR_CT-1:0]         in_dp_mask,
  input  logic                       in_blank_lz,
  input  logic [DIMMING_W-1:0]       in_bright,
  output logic                       commit_char,
  output logic [$clog2(CHAR_CT)-1:0] char_sel,
  output logic [7:0]                 seg_out,
  output logic [DIMMING_W-1:0]       char_bright,
  output logic                       busy,
  output logic                       done
);

  localparam int SEL_W   = $clog2(CHAR_CT);
  localparam int CNT_MAX = (COMMIT_HI > COMMIT_LO) ? COMMIT_HI : COMMIT_LO;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHAR_CT - 1);
  localparam logic [CNT_W-1:0] HI_END   = CNT_W'(COMMIT_HI - 1);
  localparam logic [CNT_W-1:0] LO_END   = CNT_W'(COMMIT_LO - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SEL_W-1:0]     idx_q, idx_d;
  logic [31:0]          value_q, value_d;
  logic [CHAR_CT-1:0]   dp_q, dp_d;
  logic [CHAR_CT-1:0]   blank_q, blank_d;
  logic [DIMMING_W-1:0] bright_q, bright_d;
  logic [7:0]           seg_q, seg_d;
  logic                 commit_q, commit_d;
  logic                 done_q, done_d;

  logic [CHAR_CT-1:0]   blank_vec;
  logic [SEL_W-1:0]     idx_nxt;
  logic [3:0]           conv_nib;
  logic                 conv_blank;
  logic                 conv_dp;
  logic [7:0]           conv_seg;

  // Character k blanks when nothing at or above nibble k is nonzero.
  for (genvar gi = 0; gi < CHAR_CT; gi++) begin : g_blank
    if (gi == 0) begin : g_first
      assign blank_vec[gi] = 1'b0;
    end else begin : g_rest
      assign blank_vec[gi] = in_blank_lz & ~(|(in_value >> (4 * gi)));
    end
  end

  assign idx_nxt = idx_q + SEL_W'(1);

  // Single decoder: character 0 straight from the inputs at accept, later
  // characters from the captured word one index ahead of the current one.
  always_comb begin
    if (state_q == ST_IDLE) begin
      conv_nib   = in_value[3:0];
      conv_blank = 1'b0;
      conv_dp    = in_dp_mask[0];
    end else begin
      conv_nib   = value_q[{idx_nxt, 2'b00} +: 4];
      conv_blank = blank_q[idx_nxt];
      conv_dp    = dp_q[idx_nxt];
    end
  end

  sandpiper_hex_to_seg u_hex_to_seg (
    .nibble (conv_nib),
    .blank  (conv_blank),
    .dp     (conv_dp),
    .seg    (conv_seg)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    value_d  = value_q;
    dp_d     = dp_q;
    blank_d  = blank_q;
    bright_d = bright_q;
    seg_d    = seg_q;
    commit_d = commit_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          value_d  = in_value;
          dp_d     = in_dp_mask;
          blank_d  = blank_vec;
          bright_d = in_bright;
          idx_d    = '0;
          seg_d    = conv_seg;
          commit_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (cnt_q == HI_END) begin
          cnt_d    = '0;
          commit_d = 1'b0;
          state_d  = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == LO_END) begin
          cnt_d = '0;
          if (idx_q != LAST_IDX) begin
            idx_d    = idx_nxt;
            seg_d    = conv_seg;
            commit_d = 1'b1;
            state_d  = ST_ASSERT;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        commit_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      value_q  <= '0;
      dp_q     <= '0;
      blank_q  <= '0;
      bright_q <= '0;
      seg_q    <= SEG_BLANK;
      commit_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      value_q  <= value_d;
      dp_q     <= dp_d;
      blank_q  <= blank_d;
      bright_q <= bright_d;
      seg_q    <= seg_d;
      commit_q <= commit_d;
      done_q   <= done_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign busy        = ~in_ready;
  assign commit_char = commit_q;
  assign char_sel    = idx_q;
  assign seg_out     = seg_q;
  assign char_bright = bright_q;
  assign done        = done_q;

endmodule

// File: tb/tb_sandpiper_hex_char_writer.sv
// Randomized self-checking bench: two writers (2/2 and 1/1 commit timing)
// observed by a driver model that captures on each commit_char rise.
module tb_sandpiper_hex_char_writer;

  localparam int NCH = 8;

  logic clk;
  logic rst_n;
  logic [1:0]       in_valid, in_blank_lz, in_ready, commit_char, busy, done;
  logic [1:0][31:0] in_value;
  logic [1:0][7:0]  in_dp_mask, in_bright, seg_out, char_bright;
  logic [1:0][2:0]  char_sel;

  typedef struct {
    int sel;
    int seg;
    int bright;
    int t;
    int gap;
  } cap_t;

  cap_t cap0[$];
  cap_t cap1[$];
  int   done0[$];
  int   done1[$];
  int   cyc;
  logic [1:0] prev_commit;
  int   last_fall [2];
  int   n_checks;
  int   n_fail;

  logic [7:0] glyph_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  sandpiper_hex_char_writer #(.CHAR_CT(NCH), .DIMMING_W(8), .COMMIT_HI(2), .COMMIT_LO(2)) dut (
    .sys_clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_value(in_value[0]), .in_dp_mask(in_dp_mask[0]), .in_blank_lz(in_blank_lz[0]),
    .in_bright(in_bright[0]), .commit_char(commit_char[0]), .char_sel(char_sel[0]),
    .seg_out(seg_out[0]), .char_bright(char_bright[0]), .busy(busy[0]), .done(done[0])
  );

  sandpiper_hex_char_writer #(.CHAR_CT(NCH), .DIMMING_W(8), .COMMIT_HI(1), .COMMIT_LO(1)) dut_fast (
    .sys_clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_value(in_value[1]), .in_dp_mask(in_dp_mask[1]), .in_blank_lz(in_blank_lz[1]),
    .in_bright(in_bright[1]), .commit_char(commit_char[1]), .char_sel(char_sel[1]),
    .seg_out(seg_out[1]), .char_bright(char_bright[1]), .busy(busy[1]), .done(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int hi_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int lo_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int cap_size(input int d);
    return (d == 0) ? cap0.size() : cap1.size();
  endfunction

  function automatic int done_size(input int d);
    return (d == 0) ? done0.size() : done1.size();
  endfunction

  function automatic cap_t get_cap(input int d, input int i);
    cap_t e;
    if (d == 0) e = cap0[i];
    else        e = cap1[i];
    return e;
  endfunction

  function automatic int done_at(input int d, input int i);
    return (d == 0) ? done0[i] : done1[i];
  endfunction

  task automatic clear_q(input int d);
    if (d == 0) begin cap0.delete(); done0.delete(); end
    else        begin cap1.delete(); done1.delete(); end
  endtask

  // Expected pattern for character k, straight from the display rules.
  function automatic int model_seg(input logic [31:0] v, input logic [7:0] m,
                                   input bit blz, input int k);
    logic [31:0] upper;
    int g;
    upper = v >> (4 * k);
    if (blz && k != 0 && upper == 0) g = 0;
    else                             g = int'(glyph_tab[upper[3:0]]);
    if (m[k]) g = g | 'h80;
    return g;
  endfunction

  // Driver model: latch sel/seg/bright on every commit rise.
  task automatic monitor_dut(input int d);
    cap_t e;
    if (!rst_n) begin
      prev_commit[d] = 1'b0;
    end else begin
      check("ready_vs_busy", int'(in_ready[d]), int'(!busy[d]));
      if (commit_char[d] && !prev_commit[d]) begin
        e.sel = int'(char_sel[d]);
        e.seg = int'(seg_out[d]);
        e.bright = int'(char_bright[d]);
        e.t = cyc;
        e.gap = cyc - last_fall[d];
        if (d == 0) cap0.push_back(e);
        else        cap1.push_back(e);
      end else if (!commit_char[d] && prev_commit[d]) begin
        last_fall[d] = cyc;
        if (cap_size(d) > 0) begin
          e = get_cap(d, cap_size(d) - 1);
          check("stable_sel_fall", int'(char_sel[d]), e.sel);
          check("stable_seg_fall", int'(seg_out[d]), e.seg);
        end
      end
      if (done[d]) begin
        if (d == 0) done0.push_back(cyc);
        else        done1.push_back(cyc);
        if (cap_size(d) > 0) begin
          e = get_cap(d, cap_size(d) - 1);
          check("stable_seg_done", int'(seg_out[d]), e.seg);
        end
      end
      prev_commit[d] = commit_char[d];
    end
  endtask

  initial begin
    cyc = 0;
    prev_commit = '0;
    last_fall[0] = 0;
    last_fall[1] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) monitor_dut(d);
    end
  end

  task automatic verify(input int d, input int base, input logic [31:0] v,
                        input logic [7:0] m, input bit blz, input logic [7:0] br);
    cap_t e;
    cap_t p;
    for (int k = 0; k < NCH; k++) begin
      e = get_cap(d, base + k);
      check("char_sel", e.sel, k);
      check("seg", e.seg, model_seg(v, m, blz, k));
      check("bright", e.bright, int'(br));
      if (k > 0) begin
        p = get_cap(d, base + k - 1);
        check("char_period", e.t - p.t, hi_of(d) + lo_of(d));
        check("lo_cycles", e.gap, lo_of(d));
      end
    end
  endtask

  task automatic drive(input int d, input logic [31:0] v, input logic [7:0] m,
                       input bit blz, input logic [7:0] br);
    in_value[d] = v;
    in_dp_mask[d] = m;
    in_blank_lz[d] = blz;
    in_bright[d] = br;
  endtask

  task automatic scramble(input int d);
    drive(d, $urandom, 8'($urandom), 1'($urandom), 8'($urandom));
  endtask

  task automatic run_word(input int d, input logic [31:0] v, input logic [7:0] m,
                          input bit blz, input logic [7:0] br);
    int n;
    cap_t e;
    @(negedge clk);
    clear_q(d);
    drive(d, v, m, blz, br);
    in_valid[d] = 1'b1;
    n = 0;
    while (!in_ready[d] && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    scramble(d);
    n = 0;
    while (done_size(d) == 0 && n < 200) begin @(posedge clk); n++; end
    @(negedge clk);
    check("done_count", done_size(d), 1);
    check("commit_rises", cap_size(d), NCH);
    if (cap_size(d) == NCH && done_size(d) == 1) begin
      verify(d, 0, v, m, blz, br);
      e = get_cap(d, 0);
      check("word_cycles", done_at(d, 0) - e.t, NCH * (hi_of(d) + lo_of(d)));
    end
  endtask

  task automatic back_to_back();
    int n;
    cap_t e;
    @(negedge clk);
    clear_q(0);
    drive(0, 32'hCAFE_0042, 8'h00, 1'b0, 8'h11);
    in_valid[0] = 1'b1;
    n = 0;
    while (!in_ready[0] && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    drive(0, 32'h0000_0B07, 8'h81, 1'b1, 8'h22);
    n = 0;
    while (done_size(0) == 0 && n < 200) begin @(posedge clk); n++; end
    @(negedge clk);
    in_valid[0] = 1'b0;
    scramble(0);
    n = 0;
    while (done_size(0) < 2 && n < 200) begin @(posedge clk); n++; end
    @(negedge clk);
    check("b2b_done_count", done_size(0), 2);
    check("b2b_rises", cap_size(0), 2 * NCH);
    if (done_size(0) == 2 && cap_size(0) == 2 * NCH) begin
      verify(0, 0, 32'hCAFE_0042, 8'h00, 1'b0, 8'h11);
      verify(0, NCH, 32'h0000_0B07, 8'h81, 1'b1, 8'h22);
      e = get_cap(0, NCH);
      check("b2b_rise_after_done", e.t - done_at(0, 0), 1);
      check("b2b_low_cycles", e.gap, lo_of(0) + 1);
    end
    check("b2b_ready_after", int'(in_ready[0]), 1);
  endtask

  task automatic reset_mid_word();
    int n;
    @(negedge clk);
    clear_q(0);
    drive(0, 32'h8765_4321, 8'hFF, 1'b0, 8'h5A);
    in_valid[0] = 1'b1;
    n = 0;
    while (!in_ready[0] && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    n = 0;
    while (cap_size(0) < 5 && n < 200) begin @(posedge clk); n++; end
    check("rst_reached_char4", cap_size(0), 5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_commit", int'(commit_char[0]), 0);
    check("rst_busy", int'(busy[0]), 0);
    check("rst_seg", int'(seg_out[0]), 0);
    check("rst_sel", int'(char_sel[0]), 0);
    check("rst_done", int'(done[0]), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready_after", int'(in_ready[0]), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int sh;
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    in_valid = '0;
    for (int d = 0; d < 2; d++) drive(d, 32'h0, 8'h0, 1'b0, 8'h0);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_commit", int'(commit_char[d]), 0);
      check("reset_sel", int'(char_sel[d]), 0);
      check("reset_seg", int'(seg_out[d]), 0);
      check("reset_bright", int'(char_bright[d]), 0);
      check("reset_busy", int'(busy[d]), 0);
      check("reset_done", int'(done[d]), 0);
      check("reset_ready", int'(in_ready[d]), 1);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_word(0, 32'h1234_5678, 8'h00, 1'b0, 8'h80);
    run_word(0, 32'h0000_00A0, 8'h00, 1'b1, 8'h40);
    run_word(0, 32'h0000_0000, 8'h04, 1'b1, 8'h7F);
    run_word(1, 32'h1234_5678, 8'h00, 1'b0, 8'h80);
    run_word(1, 32'h0000_0000, 8'hFF, 1'b1, 8'h01);
    back_to_back();
    reset_mid_word();
    run_word(0, 32'h00F0_0000, 8'h10, 1'b1, 8'hC3);

    for (int it = 0; it < 8; it++) begin
      for (int d = 0; d < 2; d++) begin
        v = $urandom;
        sh = $urandom_range(0, 32);
        v = (sh == 32) ? 32'h0 : (v >> sh);
        run_word(d, v, 8'($urandom), 1'($urandom), 8'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
